dff_onstate_multi: RTL and testbench
====================================

// Module: dff_onstate_multi
// PURPOSE
//  Multi-channel, parametrised run/last edge FSM with registered outputs.
//  Each channel i watches level input do[i]:
//   - r[i] stays high for the whole qualified high run.
//   - f[i] pulses for LAST_LEN cycles after the run ends.
//  Optional input glitch qualification and a synchronous clear.
//  Sits between raw strobe/level sources and control logic that wants clean start/stop framing.
// PARAMETERS
//  NCH      4  number of independent channels (>=1)
//  FILT     1  consecutive high samples needed to enter RUN (>=1); 1 = no filtering
//  LAST_LEN 1  cycles spent in LAST, i.e. width of the f pulse (>=1)
//  CW       8  width of each optional rise-event counter (>=1)
// PORTS
//  clk    in   1        rising-edge clock
//  rst_n  in   1        asynchronous active-low reset
//  clr    in   1        synchronous clear, all channels
//  en     in   NCH      per-channel enable
//  do     in   NCH      per-channel level input, sampled each clk
//  r      out  NCH      registered; high while channel is in RUN
//  f      out  NCH      registered; high while channel is in LAST
//  busy   out  1        registered; OR over channels of (nextstate != IDLE)
//  rcnt   out  NCH*CW   rise counters, channel i at [i*CW +: CW]; only with DFF_ONSTATE_CNT_EN
// BEHAVIOUR
//  Reset: all states IDLE; all internal counters 0; r=0, f=0, busy=0, rcnt=0.
//  Per-channel FSM, states IDLE, QUAL, RUN, LAST; qcnt/lcnt are per-channel counters.
//   IDLE: en & do -> RUN if FILT==1; otherwise -> QUAL with qcnt=1.
//   QUAL: !do -> IDLE (no r, no f).
//         do & (qcnt+1==FILT) -> RUN.
//         Otherwise qcnt++ and stay in QUAL.
//   RUN:  !do -> LAST with lcnt=1; otherwise stay in RUN.
//   LAST: lcnt==LAST_LEN -> IDLE; otherwise lcnt++.
//         do is ignored in LAST. A new run needs a fresh IDLE->(QUAL)->RUN pass.
//  en[i]=0: a channel in IDLE or QUAL goes (or stays) IDLE.
//           A channel in RUN or LAST completes normally (en gates only run starts).
//  clr=1: every channel -> IDLE next cycle.
//         r, f, busy = 0 next cycle; counters zeroed.
//         clr overrides all transitions.
//  Outputs are computed from nextstate and registered:
//   r[i] <= (nextstate==RUN), f[i] <= (nextstate==LAST).
//   r and f are therefore cycle-aligned with state; they are never high together.
//  Latency (FILT=1): do rises at sample edge k -> r high from k until the edge sampling do=0.
//   That edge drops r and raises f for LAST_LEN cycles.
//  Latency (FILT=N): r rises at the edge of the N-th consecutive high sample.
//  Channels are fully independent; nothing is shared except clr and busy.
//  Reset mid-run: outputs drop asynchronously; no f is produced.
// CONFIGURATION
//  DFF_ONSTATE_CNT_EN defined:
//   rcnt port present.
//   rcnt[i] increments on each transition into RUN of channel i.
//   It saturates at 2^CW-1 (no wrap) and is cleared by rst_n and by clr.
//   It updates in the same cycle r[i] rises.
//  DFF_ONSTATE_CNT_EN undefined: rcnt port and counter logic absent; all other behaviour identical.
// TESTING
//  1. NCH=4, FILT=1, LAST_LEN=1, en=4'hF; do[0] high 3 cycles then low
//     -> r[0] high 3 cycles, then f[0] high 1 cycle; other channels quiet.
//  2. FILT=3; do[1] high 2 cycles, low, then high 5 cycles
//     -> first burst: no r, no f; second burst: r[1] high from the 3rd high sample.
//  3. LAST_LEN=3; do[2] pulse, then high again during LAST
//     -> f[2] high exactly 3 cycles; that high level is ignored.
//     -> If do[2] is still high in IDLE, a new run starts.
//  4. clr asserted with ch0 in RUN and ch1 in LAST -> next cycle r=0, f=0, busy=0.
//     Deassert rst_n mid-RUN -> r drops immediately, no f afterwards.
//  5. en[3]=0 with do[3] high -> r[3] stays 0.
//     Drop en[3] while ch3 is in RUN -> RUN and LAST complete normally.
//  6. DFF_ONSTATE_CNT_EN, CW=2; 5 runs on ch0 -> rcnt[1:0] reads 1,2,3,3,3; clr -> 0.

Source files
------------

// File: rtl/dff_onstate_multi_if.sv
// Handshake bundle for dff_onstate_multi: control inputs and framed outputs.
// The rcnt signal exists only when DFF_ONSTATE_CNT_EN is defined.
interface dff_onstate_multi_if #(
  parameter int NCH = 4,
  parameter int CW  = 8
);
  logic           clr;
  logic [NCH-1:0] en;
  logic [NCH-1:0] do_in;
  logic [NCH-1:0] r;
  logic [NCH-1:0] f;
  logic           busy;
`ifdef DFF_ONSTATE_CNT_EN
  logic [NCH*CW-1:0] rcnt;
`endif

  modport master (
    output clr, en, do_in,
`ifdef DFF_ONSTATE_CNT_EN
    input  rcnt,
`endif
    input  r, f, busy
  );

  modport slave (
    input  clr, en, do_in,
`ifdef DFF_ONSTATE_CNT_EN
    output rcnt,
`endif
    output r, f, busy
  );
endinterface

// File: rtl/dff_onstate_multi.sv
// Multi-channel run/last framing FSM with registered r/f/busy outputs.
// Define DFF_ONSTATE_CNT_EN to add saturating per-channel rise counters.
module dff_onstate_multi #(
  parameter int NCH      = 4,
  parameter int FILT     = 1,
  parameter int LAST_LEN = 1,
  parameter int CW       = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  dff_onstate_multi_if.slave  bus
);

  localparam int QW = $clog2(FILT + 1);
  localparam int LW = $clog2(LAST_LEN + 1);

  typedef enum logic [1:0] {
    IDLE,
    QUAL,
    RUN,
    LAST
  } st_e;

  st_e            st_q   [NCH];
  st_e            st_d   [NCH];
  logic [QW-1:0]  qcnt_q [NCH];
  logic [QW-1:0]  qcnt_d [NCH];
  logic [LW-1:0]  lcnt_q [NCH];
  logic [LW-1:0]  lcnt_d [NCH];
  logic [NCH-1:0] r_q, r_d;
  logic [NCH-1:0] f_q, f_d;
  logic           busy_q, busy_d;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      st_d[i]   = st_q[i];
      qcnt_d[i] = qcnt_q[i];
      lcnt_d[i] = lcnt_q[i];
      if (bus.clr) begin
        st_d[i]   = IDLE;
        qcnt_d[i] = '0;
        lcnt_d[i] = '0;
      end else begin
        unique case (st_q[i])
          IDLE: begin
            if (bus.en[i] && bus.do_in[i]) begin
              if (FILT == 1) begin
                st_d[i] = RUN;
              end else begin
                st_d[i]   = QUAL;
                qcnt_d[i] = QW'(1);
              end
            end
          end
          QUAL: begin
            // en only gates starts, so a disabled qualifier aborts too
            if (!bus.en[i] || !bus.do_in[i]) begin
              st_d[i]   = IDLE;
              qcnt_d[i] = '0;
            end else if (qcnt_q[i] + QW'(1) == QW'(FILT)) begin
              st_d[i]   = RUN;
              qcnt_d[i] = '0;
            end else begin
              qcnt_d[i] = qcnt_q[i] + QW'(1);
            end
          end
          RUN: begin
            if (!bus.do_in[i]) begin
              st_d[i]   = LAST;
              lcnt_d[i] = LW'(1);
            end
          end
          LAST: begin
            if (lcnt_q[i] == LW'(LAST_LEN)) begin
              st_d[i]   = IDLE;
              lcnt_d[i] = '0;
            end else begin
              lcnt_d[i] = lcnt_q[i] + LW'(1);
            end
          end
          default: st_d[i] = IDLE;
        endcase
      end
    end
  end

  always_comb begin
    r_d    = '0;
    f_d    = '0;
    busy_d = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      r_d[i] = (st_d[i] == RUN);
      f_d[i] = (st_d[i] == LAST);
      busy_d = busy_d | (st_d[i] != IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        st_q[i]   <= IDLE;
        qcnt_q[i] <= '0;
        lcnt_q[i] <= '0;
      end
      r_q    <= '0;
      f_q    <= '0;
      busy_q <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        st_q[i]   <= st_d[i];
        qcnt_q[i] <= qcnt_d[i];
        lcnt_q[i] <= lcnt_d[i];
      end
      r_q    <= r_d;
      f_q    <= f_d;
      busy_q <= busy_d;
    end
  end

  assign bus.r    = r_q;
  assign bus.f    = f_q;
  assign bus.busy = busy_q;

`ifdef DFF_ONSTATE_CNT_EN
  logic [CW-1:0] cnt_q [NCH];
  logic [CW-1:0] cnt_d [NCH];

  // Saturating count of entries into RUN
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (bus.clr) begin
        cnt_d[i] = '0;
      end else if (st_d[i] == RUN && st_q[i] != RUN
                   && cnt_q[i] != '1) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    bus.rcnt = '0;
    for (int i = 0; i < NCH; i++) bus.rcnt[i*CW +: CW] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_dff_onstate_multi.sv
// Scoreboard bench: two DUT configurations driven with shared stimulus.
// A run/tail/streak reference model predicts outputs for each edge.
module tb_dff_onstate_multi;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dff_onstate_multi_if #(.NCH(4), .CW(8)) if0 ();
  dff_onstate_multi_if #(.NCH(4), .CW(2)) if1 ();

  dff_onstate_multi #(
    .NCH(4), .FILT(1), .LAST_LEN(1), .CW(8)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave)
  );

  dff_onstate_multi #(
    .NCH(4), .FILT(3), .LAST_LEN(3), .CW(2)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave)
  );

  typedef struct {
    logic [3:0]  r0, f0, r1, f1;
    logic        b0, b1;
    logic [31:0] c0;
    logic [7:0]  c1;
  } exp_t;

  exp_t q[$];
  int errs = 0;
  int checks = 0;

  int filt_v [2] = '{1, 3};
  int last_v [2] = '{1, 3};
  int cmax_v [2] = '{255, 3};
  int  streak [2][4];
  int  tail   [2][4];
  bit  run    [2][4];
  int  cnt    [2][4];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4; i++) begin
        streak[d][i] = 0;
        tail[d][i]   = 0;
        run[d][i]    = 0;
        cnt[d][i]    = 0;
      end
  endtask

  // Channel behaviour: a run starts after FILT enabled high samples,
  // ends on the first low sample, then a LAST_LEN tail ignores input.
  task automatic model_edge(input int d, input logic [3:0] e,
                            input logic [3:0] dv, input logic c);
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        run[d][i] = 0; tail[d][i] = 0;
        streak[d][i] = 0; cnt[d][i] = 0;
      end else if (tail[d][i] > 0) begin
        tail[d][i]--;
      end else if (run[d][i]) begin
        if (!dv[i]) begin
          run[d][i]  = 0;
          tail[d][i] = last_v[d];
        end
      end else if (e[i] && dv[i]) begin
        streak[d][i]++;
        if (streak[d][i] >= filt_v[d]) begin
          run[d][i] = 1;
          streak[d][i] = 0;
          if (cnt[d][i] < cmax_v[d]) cnt[d][i]++;
        end
      end else begin
        streak[d][i] = 0;
      end
    end
  endtask

  function automatic exp_t snap();
    exp_t x;
    x.r0 = '0; x.f0 = '0; x.r1 = '0; x.f1 = '0;
    x.b0 = 0; x.b1 = 0; x.c0 = '0; x.c1 = '0;
    for (int i = 0; i < 4; i++) begin
      x.r0[i] = run[0][i];
      x.f0[i] = tail[0][i] > 0;
      x.r1[i] = run[1][i];
      x.f1[i] = tail[1][i] > 0;
      x.b0 |= run[0][i] || tail[0][i] > 0 || streak[0][i] > 0;
      x.b1 |= run[1][i] || tail[1][i] > 0 || streak[1][i] > 0;
      x.c0[i*8 +: 8] = 8'(cnt[0][i]);
      x.c1[i*2 +: 2] = 2'(cnt[1][i]);
    end
    return x;
  endfunction

  task automatic step(input logic [3:0] e, input logic [3:0] dv,
                      input logic c);
    exp_t x;
    if0.en = e; if0.do_in = dv; if0.clr = c;
    if1.en = e; if1.do_in = dv; if1.clr = c;
    model_edge(0, e, dv, c);
    model_edge(1, e, dv, c);
    x = snap();
    @(posedge clk);
    q.push_back(x);
    #1;
  endtask

  task automatic hold(input int n, input logic [3:0] e,
                      input logic [3:0] dv);
    for (int k = 0; k < n; k++) step(e, dv, 1'b0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".r0"}, 32'(if0.r), 32'h0);
    chk({nm, ".f0"}, 32'(if0.f), 32'h0);
    chk({nm, ".b0"}, 32'(if0.busy), 32'h0);
    chk({nm, ".r1"}, 32'(if1.r), 32'h0);
    chk({nm, ".f1"}, 32'(if1.f), 32'h0);
    chk({nm, ".b1"}, 32'(if1.busy), 32'h0);
`ifdef DFF_ONSTATE_CNT_EN
    chk({nm, ".c0"}, if0.rcnt, 32'h0);
    chk({nm, ".c1"}, 32'(if1.rcnt), 32'h0);
`endif
  endtask

  // Monitor: outputs are valid every cycle once an edge was predicted
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      chk("r0", 32'(if0.r), 32'(x.r0));
      chk("f0", 32'(if0.f), 32'(x.f0));
      chk("busy0", 32'(if0.busy), 32'(x.b0));
      chk("r1", 32'(if1.r), 32'(x.r1));
      chk("f1", 32'(if1.f), 32'(x.f1));
      chk("busy1", 32'(if1.busy), 32'(x.b1));
      chk("rf_excl0", 32'(if0.r & if0.f), 32'h0);
      chk("rf_excl1", 32'(if1.r & if1.f), 32'h0);
`ifdef DFF_ONSTATE_CNT_EN
      chk("rcnt0", if0.rcnt, x.c0);
      chk("rcnt1", 32'(if1.rcnt), 32'(x.c1));
`endif
    end
  end

  initial begin
    logic [3:0] e, dv;
    if0.en = '0; if0.do_in = '0; if0.clr = 1'b0;
    if1.en = '0; if1.do_in = '0; if1.clr = 1'b0;
    model_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2 chk_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // single run on ch0
    hold(3, 4'hF, 4'h1);
    hold(4, 4'hF, 4'h0);
    // short burst then long burst on ch1
    hold(2, 4'hF, 4'h2);
    hold(1, 4'hF, 4'h0);
    hold(5, 4'hF, 4'h2);
    hold(5, 4'hF, 4'h0);
    // ch2 re-asserted during LAST, still high at IDLE
    hold(3, 4'hF, 4'h4);
    hold(1, 4'hF, 4'h0);
    hold(8, 4'hF, 4'h4);
    hold(6, 4'hF, 4'h0);
    // clr with ch0 in RUN and ch1 in LAST
    hold(4, 4'hF, 4'h3);
    hold(1, 4'hF, 4'h1);
    step(4'hF, 4'h1, 1'b1);
    hold(3, 4'hF, 4'h0);
    // async reset mid-run
    hold(5, 4'hF, 4'h1);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1 chk_zero("midrun_rst");
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    hold(6, 4'hF, 4'h0);
    // ch3 disabled, then enable drop mid-run
    hold(5, 4'h7, 4'h8);
    hold(4, 4'hF, 4'h8);
    hold(3, 4'h7, 4'h8);
    hold(6, 4'h7, 4'h0);
    // repeated runs to saturate counters
    for (int k = 0; k < 5; k++) begin
      hold(4, 4'hF, 4'h1);
      hold(5, 4'hF, 4'h0);
    end
    step(4'hF, 4'h0, 1'b1);
    hold(2, 4'hF, 4'h0);

    // random traffic with long-ish level runs
    e = 4'hF; dv = 4'h0;
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(3) == 0) dv[i] = ~dv[i];
        if ($urandom_range(15) == 0) e[i] = ~e[i];
      end
      step(e, dv, ($urandom_range(79) == 0));
    end

    @(negedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
